// File: rtl/iobus_write_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Package : otter_iobus_pkg
//  Shared types and IO address map for the OTTER memory-mapped IO bus.
//  Revision: 1.0  initial release
// ============================================================================
package otter_iobus_pkg;

  // One posted store: address and data travel together through the buffer
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } iobus_wr_t;

  // IO address map, shared with the peripheral decoder
  localparam logic [31:0] IO_BASE_ADDR     = 32'h1100_0000;
  localparam logic [31:0] IO_SWITCHES_ADDR = 32'h1100_0000;
  localparam logic [31:0] IO_LEDS_ADDR     = 32'h1100_0020;
  localparam logic [31:0] IO_SSEG_ADDR     = 32'h1104_0000;
  localparam logic [31:0] IO_KEYBOARD_ADDR = 32'h1108_0000;

endpackage : otter_iobus_pkg
`default_nettype wire

// File: rtl/iobus_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : iobus_fifo
//  Generic synchronous circular FIFO of iobus_wr_t entries. DEPTH must be a
//  power of two. Pushes when full and pops when empty are ignored.
//  Revision: 1.0  initial release
// ============================================================================
module iobus_fifo
  import otter_iobus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  logic      pop_i,
  input  iobus_wr_t din_i,
  output iobus_wr_t dout_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(DEPTH);

  iobus_wr_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Next-state for pointers (wrapping at DEPTH-1) and occupancy count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Pointer and count registers; reset discards all queued entries
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful while counted as occupied
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule : iobus_fifo
`default_nettype wire

// File: rtl/iobus_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module  : iobus_write_buffer
//  Posted-write buffer between the OTTER memory-stage IO bus and the
//  memory-mapped peripherals. Stalls the CPU only when the queue is full.
//  Optional feature macro: IOBUS_WB_STATS_EN (write/stall statistics).
//  Revision: 1.0  initial release
// ============================================================================
module iobus_write_buffer
  import otter_iobus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IOBUS_WR,
  input  logic [31:0]      IOBUS_ADDR,
  input  logic [31:0]      IOBUS_OUT,
  output logic             STALL,
  output logic             BUF_EMPTY,
  output logic             PERIPH_VALID,
  output logic [31:0]      PERIPH_ADDR,
  output logic [31:0]      PERIPH_WDATA,
  input  logic             PERIPH_READY,
  output logic [CNT_W-1:0] WR_COUNT,
  output logic [CNT_W-1:0] STALL_COUNT
);

  iobus_wr_t fifo_din, fifo_dout;
  iobus_wr_t last_q;
  logic      fifo_full, fifo_empty;
  logic      push, pop;

  // STALL depends only on the strobe and registered fullness, never on READY,
  // so a same-cycle pop cannot open a slot for the refused write
  assign STALL     = IOBUS_WR && fifo_full;
  assign push      = IOBUS_WR && !fifo_full;
  assign pop       = !fifo_empty && PERIPH_READY;
  assign fifo_din  = '{addr: IOBUS_ADDR, data: IOBUS_OUT};
  assign BUF_EMPTY = fifo_empty;

  iobus_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Remember the most recently drained entry so outputs hold it while empty
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)  last_q <= '0;
    else if (pop)  last_q <= fifo_dout;
  end

  // Output stage: head entry while valid, otherwise the last drained entry
  always_comb begin
    PERIPH_VALID = !fifo_empty;
    PERIPH_ADDR  = last_q.addr;
    PERIPH_WDATA = last_q.data;
    if (!fifo_empty) begin
      PERIPH_ADDR  = fifo_dout.addr;
      PERIPH_WDATA = fifo_dout.data;
    end
  end

`ifdef IOBUS_WB_STATS_EN
  logic [CNT_W-1:0] wr_count_q, wr_count_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  // Saturating statistics counters: stop at all-ones instead of wrapping
  always_comb begin
    wr_count_d    = wr_count_q;
    stall_count_d = stall_count_q;
    if (push  && (wr_count_q    != '1)) wr_count_d    = wr_count_q + 1'b1;
    if (STALL && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
  end

  // Counter registers, cleared only by reset
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      wr_count_q    <= wr_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign WR_COUNT    = wr_count_q;
  assign STALL_COUNT = stall_count_q;
`else
  assign WR_COUNT    = '0;
  assign STALL_COUNT = '0;
`endif

endmodule : iobus_write_buffer
`default_nettype wire

// File: tb/tb_iobus_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_iobus_write_buffer
//  Self-checking bench for iobus_write_buffer (DEPTH=4, CNT_W=16).
//  Revision: 1.0  initial release
// ============================================================================
module tb_iobus_write_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic             IOBUS_WR;
  logic [31:0]      IOBUS_ADDR;
  logic [31:0]      IOBUS_OUT;
  logic             STALL;
  logic             BUF_EMPTY;
  logic             PERIPH_VALID;
  logic [31:0]      PERIPH_ADDR;
  logic [31:0]      PERIPH_WDATA;
  logic             PERIPH_READY;
  logic [CNT_W-1:0] WR_COUNT;
  logic [CNT_W-1:0] STALL_COUNT;

  int total = 0;
  int bad   = 0;

  iobus_write_buffer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .IOBUS_WR     (IOBUS_WR),
    .IOBUS_ADDR   (IOBUS_ADDR),
    .IOBUS_OUT    (IOBUS_OUT),
    .STALL        (STALL),
    .BUF_EMPTY    (BUF_EMPTY),
    .PERIPH_VALID (PERIPH_VALID),
    .PERIPH_ADDR  (PERIPH_ADDR),
    .PERIPH_WDATA (PERIPH_WDATA),
    .PERIPH_READY (PERIPH_READY),
    .WR_COUNT     (WR_COUNT),
    .STALL_COUNT  (STALL_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rdy;
    logic        e_stall;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_empty;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    IOBUS_WR     = wr;
    IOBUS_ADDR   = a;
    IOBUS_OUT    = d;
    PERIPH_READY = rdy;
  endtask

  // Move to the sampling point, away from the active edge
  task automatic sample();
    @(negedge CLK);
  endtask

  // Cross the active edge and step a little past it before driving again
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Single write, then back-pressure with 5 writes (data 1..5)
    vecs[0]  = '{1'b1, 32'h1100_0020, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0,          32'h0,          1'b1};
    vecs[1]  = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b1, 32'h1100_0020, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 32'h1100_0020, 32'hDEAD_BEEF, 1'b1};
    vecs[3]  = '{1'b1, 32'h1100_0101, 32'h1,         1'b0, 1'b0, 1'b0, 32'h1100_0020, 32'hDEAD_BEEF, 1'b1};
    vecs[4]  = '{1'b1, 32'h1100_0102, 32'h2,         1'b0, 1'b0, 1'b1, 32'h1100_0101, 32'h1,         1'b0};
    vecs[5]  = '{1'b1, 32'h1100_0103, 32'h3,         1'b0, 1'b0, 1'b1, 32'h1100_0101, 32'h1,         1'b0};
    vecs[6]  = '{1'b1, 32'h1100_0104, 32'h4,         1'b0, 1'b0, 1'b1, 32'h1100_0101, 32'h1,         1'b0};
    vecs[7]  = '{1'b1, 32'h1100_0105, 32'h5,         1'b0, 1'b1, 1'b1, 32'h1100_0101, 32'h1,         1'b0};
    vecs[8]  = '{1'b1, 32'h1100_0105, 32'h5,         1'b0, 1'b1, 1'b1, 32'h1100_0101, 32'h1,         1'b0};
    vecs[9]  = '{1'b1, 32'h1100_0105, 32'h5,         1'b1, 1'b1, 1'b1, 32'h1100_0101, 32'h1,         1'b0};
    vecs[10] = '{1'b1, 32'h1100_0105, 32'h5,         1'b1, 1'b0, 1'b1, 32'h1100_0102, 32'h2,         1'b0};
    vecs[11] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b1, 32'h1100_0103, 32'h3,         1'b0};
    vecs[12] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b1, 32'h1100_0104, 32'h4,         1'b0};
    vecs[13] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b1, 32'h1100_0105, 32'h5,         1'b0};
    vecs[14] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 32'h1100_0105, 32'h5,         1'b1};

    // Reset state, with the strobe high to show it is ignored
    RESET_N = 1'b0;
    drive(1'b1, 32'h1100_0000, 32'hFFFF_FFFF, 1'b0);
    #2;
    chk("rst_valid", 32'(PERIPH_VALID), 32'h0);
    chk("rst_empty", 32'(BUF_EMPTY),    32'h1);
    chk("rst_stall", 32'(STALL),        32'h0);
    chk("rst_addr",  PERIPH_ADDR,       32'h0);
    chk("rst_wdata", PERIPH_WDATA,      32'h0);
    chk("rst_wrcnt", 32'(WR_COUNT),     32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    RESET_N = 1'b1;
    tick();

    // Table: single write and full-queue back-pressure
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].rdy);
      sample();
      chk($sformatf("v%0d_stall", i), 32'(STALL),        32'(vecs[i].e_stall));
      chk($sformatf("v%0d_valid", i), 32'(PERIPH_VALID), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_addr",  i), PERIPH_ADDR,       vecs[i].e_addr);
      chk($sformatf("v%0d_wdata", i), PERIPH_WDATA,      vecs[i].e_wdata);
      chk($sformatf("v%0d_empty", i), 32'(BUF_EMPTY),    32'(vecs[i].e_empty));
      tick();
    end

`ifdef IOBUS_WB_STATS_EN
    // 1 single write + 5 back-pressure writes; STALL high in vectors 7, 8, 9
    chk("stats_wr",    32'(WR_COUNT),    32'd6);
    chk("stats_stall", 32'(STALL_COUNT), 32'd3);
`else
    chk("stats_wr_off",    32'(WR_COUNT),    32'd0);
    chk("stats_stall_off", 32'(STALL_COUNT), 32'd0);
`endif

    // Wrap-around: continuous push/pop, data 0x10..0x19, occupancy stays 1
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h1100_0200 + 32'(i), 32'h10 + 32'(i), 1'b1);
      sample();
      chk($sformatf("wrap%0d_stall", i), 32'(STALL), 32'h0);
      if (i > 0) begin
        chk($sformatf("wrap%0d_valid", i), 32'(PERIPH_VALID), 32'h1);
        chk($sformatf("wrap%0d_wdata", i), PERIPH_WDATA, 32'h10 + 32'(i - 1));
        chk($sformatf("wrap%0d_addr",  i), PERIPH_ADDR,  32'h1100_0200 + 32'(i - 1));
      end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    sample();
    chk("wrap_last_wdata", PERIPH_WDATA, 32'h19);
    chk("wrap_last_valid", 32'(PERIPH_VALID), 32'h1);
    tick();
    sample();
    chk("wrap_drained", 32'(BUF_EMPTY), 32'h1);
    tick();

    // Hold stability: READY 0,0,1 against one queued entry
    drive(1'b1, 32'h1100_0040, 32'h0000_AA55, 1'b0);
    tick();
    begin
      logic rdy_seq [3];
      rdy_seq[0] = 1'b0;
      rdy_seq[1] = 1'b0;
      rdy_seq[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
        drive(1'b0, 32'h0, 32'h0, rdy_seq[i]);
        sample();
        chk($sformatf("hold%0d_valid", i), 32'(PERIPH_VALID), 32'h1);
        chk($sformatf("hold%0d_addr",  i), PERIPH_ADDR,  32'h1100_0040);
        chk($sformatf("hold%0d_wdata", i), PERIPH_WDATA, 32'h0000_AA55);
        tick();
      end
    end
    sample();
    chk("hold_popped", 32'(PERIPH_VALID), 32'h0);
    tick();

    // Reset mid-drain with 3 entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h1100_0300 + 32'(i), 32'h31 + 32'(i), 1'b0);
      tick();
    end
    drive(1'b1, 32'h1100_0310, 32'h99, 1'b1);
    sample();
    chk("pre_rst_valid", 32'(PERIPH_VALID), 32'h1);
    chk("pre_rst_wdata", PERIPH_WDATA, 32'h31);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(PERIPH_VALID), 32'h0);
    chk("mid_rst_empty", 32'(BUF_EMPTY),    32'h1);
    chk("mid_rst_stall", 32'(STALL),        32'h0);
    chk("mid_rst_wdata", PERIPH_WDATA,      32'h0);
    @(posedge CLK);
    @(negedge CLK);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      sample();
      chk($sformatf("post_rst%0d_valid", i), 32'(PERIPH_VALID), 32'h0);
      chk($sformatf("post_rst%0d_empty", i), 32'(BUF_EMPTY),    32'h1);
    end
    chk("post_rst_wrcnt", 32'(WR_COUNT), 32'h0);
    tick();

`ifdef IOBUS_WB_STATS_EN
    // Saturation: 2^CNT_W + 3 accepted writes must stop at all-ones
    drive(1'b1, 32'h1100_0400, 32'h5A, 1'b1);
    repeat ((1 << CNT_W) + 3) @(posedge CLK);
    #1;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    sample();
    chk("sat_wr",    32'(WR_COUNT),    32'(16'hFFFF));
    chk("sat_stall", 32'(STALL_COUNT), 32'h0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_iobus_write_buffer
`default_nettype wire
